mem_port_arbiter: RTL and testbench

//  Shares the single-port unified memory of the multicycle core between two requesters:
//  - instruction fetch (IF), driven by the control FSM during its fetch/wait states
//  - data access (D), for loads and stores

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states and access owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef enum logic {OWN_IF, OWN_D} owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the memory port: data side first, unless fetch has already lost
// STARVE_MAX consecutive times while waiting.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   take,
  output owner_e owner
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          d_wins;

  assign d_wins = d_req && !(if_req && (starve_cnt == SMAX));
  assign owner  = d_wins ? OWN_D : OWN_IF;

  // Counts only D wins that overtook a waiting fetch; a D win with no fetch pending leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (take) begin
      if (!d_wins) begin
        starve_cnt <= '0;
      end else if (if_req && (starve_cnt != SMAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port memory between instruction fetch and data access,
// one access in flight, data side first with a fetch starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  // Requesters hold req and payload until their 1-cycle gnt. Requests are sampled only in
  // IDLE: a req still high on return to IDLE is a new request, one dropped early is withdrawn.
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output state_e            dbg_state
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LAT - 1);

  state_e        state;
  owner_e        owner_q;
  owner_e        pick_owner;
  logic          we_q;
  logic [LW-1:0] lat_cnt;
  logic          take;

  assign take      = (state == IDLE) && (if_req || d_req);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk   (clk),
    .rst   (rst),
    .if_req(if_req),
    .d_req (d_req),
    .take  (take),
    .owner (pick_owner)
  );

  // Strobes are loaded on the way into ISSUE so they are registered and line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner_q   <= OWN_IF;
      we_q      <= 1'b0;
      lat_cnt   <= '0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            owner_q <= pick_owner;
            state   <= ISSUE;
            if (pick_owner == OWN_D) begin
              we_q      <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              d_gnt     <= 1'b1;
              mem_wr    <= d_we;
              mem_rd    <= !d_we;
            end else begin
              we_q     <= 1'b0;
              mem_addr <= if_addr;
              if_gnt   <= 1'b1;
              mem_rd   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (we_q) begin
            state <= IDLE;
          end else begin
            state   <= WAIT;
            lat_cnt <= LAT_LOAD;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state <= RESP;
            if (owner_q == OWN_D) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner sequences, latency
// builds MEM_LAT=1/2/4, and randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;
  localparam int STARVE_MAX = 3;
  localparam int NI         = 3;
  localparam int LAT0       = 2;
  localparam logic [DATA_W-1:0] JUNK = 64'hA5A5_5A5A_C3C3_3C3C;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared inputs, per-instance outputs ----------------
  logic              if_req, d_req, d_we;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;

  logic [NI-1:0]     if_gnt_a, if_rvalid_a, d_gnt_a, d_rvalid_a, mem_rd_a, mem_wr_a, busy_a;
  logic [DATA_W-1:0] if_rdata_a [NI];
  logic [DATA_W-1:0] d_rdata_a [NI];
  logic [ADDR_W-1:0] mem_addr_a [NI];
  logic [DATA_W-1:0] mem_wdata_a [NI];
  logic [DATA_W-1:0] mem_rdata_a [NI];
  state_e            dbg_state_a [NI];

  // Memory behind instance 0; other instances see only the address-derived contents.
  logic [DATA_W-1:0] mem_arr [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] rd_val(input bit use_arr, input logic [ADDR_W-1:0] a);
    if (use_arr && mem_arr.exists(a)) return mem_arr[a];
    return {a, ~a};
  endfunction

  function automatic int lat_of(input int g);
    return (g == 1) ? 1 : (g == 2) ? 4 : 2;
  endfunction

  always @(posedge clk) begin
    if (mem_wr_a[0]) mem_arr[mem_addr_a[0]] = mem_wdata_a[0];
  end

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 1) ? 1 : (g == 2) ? 4 : 2;
    logic [DATA_W:0] pipe [LAT];

    mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT), .STARVE_MAX(STARVE_MAX)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt_a[g]),
      .if_rvalid(if_rvalid_a[g]),
      .if_rdata (if_rdata_a[g]),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt_a[g]),
      .d_rvalid (d_rvalid_a[g]),
      .d_rdata  (d_rdata_a[g]),
      .mem_rd   (mem_rd_a[g]),
      .mem_wr   (mem_wr_a[g]),
      .mem_addr (mem_addr_a[g]),
      .mem_wdata(mem_wdata_a[g]),
      .mem_rdata(mem_rdata_a[g]),
      .busy     (busy_a[g]),
      .dbg_state(dbg_state_a[g])
    );

    // Read data is on the bus only in the cycle MEM_LAT after the strobe; junk otherwise.
    assign mem_rdata_a[g] = pipe[LAT-1][DATA_W] ? pipe[LAT-1][DATA_W-1:0] : JUNK;

    always @(posedge clk) begin
      pipe[0] <= {mem_rd_a[g], rd_val(g == 0, mem_addr_a[g])};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // ---------------- checking helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] ctl0();
    return {if_gnt_a[0], d_gnt_a[0], mem_rd_a[0], mem_wr_a[0], if_rvalid_a[0], d_rvalid_a[0], busy_a[0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit                is_d;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                rv_k;    // cycle offset of rvalid, 0 = none
    int                idle_k;  // first cycle offset with busy low
    logic [DATA_W-1:0] rdata;
  } vec_t;

  vec_t vecs [7];

  // ---------------- scoreboard / reference model state ----------------
  logic [DATA_W-1:0] if_exp_q [$];
  logic [DATA_W-1:0] d_exp_q [$];
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return {a, ~a};
  endfunction

  int                gc [NI];
  int                rc [NI];
  logic [DATA_W-1:0] rdv [NI];
  logic [ADDR_W-1:0] a;
  logic [6:0]        e;
  logic [7:0]        order;
  int                k, n_gnt, gap, max_gap, seen_ifg, seen_drv;

  // model
  int                free_at, tx_gnt, tx_rv, starve;
  owner_e            tx_own;
  bit                tx_we, dw, if_cool, d_cool;
  logic [ADDR_W-1:0] tx_addr;
  logic [DATA_W-1:0] tx_wdata, last_if, last_d, v;

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ctl", ctl0(), 7'b0);
    check("rst_mem_addr", mem_addr_a[0], '0);
    check("rst_mem_wdata", mem_wdata_a[0], '0);
    check("rst_if_rdata", if_rdata_a[0], '0);
    check("rst_d_rdata", d_rdata_a[0], '0);
    check("rst_state", dbg_state_a[0], IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Latency across MEM_LAT=2/1/4 builds, one IF read then one D load
    for (int t = 0; t < 2; t++) begin
      a = (t == 0) ? 32'h80 : 32'h88;
      for (int g = 0; g < NI; g++) begin gc[g] = -1; rc[g] = -1; rdv[g] = '0; end
      if (t == 0) begin if_req = 1'b1; if_addr = a; end
      else begin d_req = 1'b1; d_we = 1'b0; d_addr = a; end
      for (int kk = 1; kk <= 10; kk++) begin
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
          if (((t == 0) ? if_gnt_a[g] : d_gnt_a[g]) && gc[g] < 0) gc[g] = kk;
          if ((t == 0) ? if_rvalid_a[g] : d_rvalid_a[g]) begin
            rc[g]  = kk;
            rdv[g] = (t == 0) ? if_rdata_a[g] : d_rdata_a[g];
          end
        end
        if (kk == 1) idle_inputs();
      end
      for (int g = 0; g < NI; g++) begin
        check($sformatf("lat_t%0d_i%0d_gnt", t, g), gc[g], 1);
        check($sformatf("lat_t%0d_i%0d_rv", t, g), rc[g], 1 + lat_of(g) + 1);
        check($sformatf("lat_t%0d_i%0d_data", t, g), rdv[g], {a, ~a});
      end
    end

    // Table-driven single transactions from IDLE on the MEM_LAT=2 instance
    vecs[0] = '{0, 0, 32'h40,  64'h0,                   4, 5, 64'h0000_0040_FFFF_FFBF};
    vecs[1] = '{1, 1, 32'h100, 64'hDEAD,                0, 2, 64'h0};
    vecs[2] = '{1, 0, 32'h100, 64'h0,                   4, 5, 64'hDEAD};
    vecs[3] = '{0, 0, 32'h100, 64'h0,                   4, 5, 64'hDEAD};
    vecs[4] = '{1, 1, 32'h40,  64'h0123_4567_89AB_CDEF, 0, 2, 64'h0};
    vecs[5] = '{0, 0, 32'h40,  64'h0,                   4, 5, 64'h0123_4567_89AB_CDEF};
    vecs[6] = '{1, 0, 32'h200, 64'h0,                   4, 5, 64'h0000_0200_FFFF_FDFF};
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_d) begin
        d_req = 1'b1; d_we = vecs[i].we; d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
      end else begin
        if_req = 1'b1; if_addr = vecs[i].addr;
      end
      for (int kk = 1; kk <= 7; kk++) begin
        @(negedge clk);
        e = {kk == 1 && !vecs[i].is_d, kk == 1 && vecs[i].is_d, kk == 1 && !vecs[i].we,
             kk == 1 && vecs[i].we, kk == vecs[i].rv_k && !vecs[i].is_d,
             kk == vecs[i].rv_k && vecs[i].is_d, kk < vecs[i].idle_k};
        check($sformatf("vec%0d_k%0d_ctl", i, kk), ctl0(), e);
        if (kk == 1) begin
          check($sformatf("vec%0d_mem_addr", i), mem_addr_a[0], vecs[i].addr);
          if (vecs[i].we) check($sformatf("vec%0d_mem_wdata", i), mem_wdata_a[0], vecs[i].wdata);
          idle_inputs();
        end
        if (kk == vecs[i].rv_k)
          check($sformatf("vec%0d_rdata", i),
                vecs[i].is_d ? d_rdata_a[0] : if_rdata_a[0], vecs[i].rdata);
      end
    end

    // Reset in the middle of a D load's WAIT
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstw_ctl", ctl0(), 7'b0);
    check("rstw_mem_addr", mem_addr_a[0], '0);
    check("rstw_mem_wdata", mem_wdata_a[0], '0);
    check("rstw_if_rdata", if_rdata_a[0], '0);
    check("rstw_d_rdata", d_rdata_a[0], '0);
    check("rstw_state", dbg_state_a[0], IDLE);
    @(negedge clk);
    rst = 1'b0;
    seen_drv = 0;
    repeat (8) begin
      @(negedge clk);
      if (d_rvalid_a[0]) seen_drv++;
    end
    check("rstw_no_rvalid", seen_drv, 0);

    // Both requesting continuously after reset: D,D,D,IF,D,D,D,IF
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    order = '0; n_gnt = 0; gap = 0; max_gap = 0;
    for (int kk = 0; kk < 200 && n_gnt < 8; kk++) begin
      @(negedge clk);
      if (d_gnt_a[0] || if_gnt_a[0]) begin
        order = {order[6:0], d_gnt_a[0]};
        n_gnt++;
        gap++;
        if (gap > max_gap) max_gap = gap;
        if (if_gnt_a[0]) gap = 0;
      end
    end
    idle_inputs();
    check("starve_n_gnt", n_gnt, 8);
    check("starve_order", order, 8'b1110_1110);
    check("starve_max_gap_le4", max_gap <= 4, 1);
    repeat (10) @(negedge clk);

    // Withdrawn fetch request raised for one cycle during a D load's WAIT
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    seen_ifg = 0; seen_drv = 0;
    for (int kk = 1; kk <= 10; kk++) begin
      @(negedge clk);
      if (if_gnt_a[0]) seen_ifg++;
      if (d_rvalid_a[0]) seen_drv++;
      if (kk == 1) idle_inputs();
      if (kk == 2) begin if_req = 1'b1; if_addr = 32'h300; end
      if (kk == 3) if_req = 1'b0;
    end
    check("withdraw_no_if_gnt", seen_ifg, 0);
    check("withdraw_d_rvalid", seen_drv, 1);

    // Randomized traffic against the transaction-level model
    apply_reset();
    free_at = cyc + 1; tx_gnt = -1; tx_rv = -1; starve = 0;
    tx_own = OWN_IF; tx_we = 0; tx_addr = '0; tx_wdata = '0;
    last_if = '0; last_d = '0; if_cool = 0; d_cool = 0;
    repeat (2000) begin
      @(negedge clk);
      k = cyc;
      e = {tx_gnt == k && tx_own == OWN_IF, tx_gnt == k && tx_own == OWN_D,
           tx_gnt == k && !tx_we, tx_gnt == k && tx_we,
           tx_rv == k && tx_own == OWN_IF, tx_rv == k && tx_own == OWN_D, k != free_at};
      check("rnd_ctl", ctl0(), e);
      if (tx_gnt == k) begin
        check("rnd_mem_addr", mem_addr_a[0], tx_addr);
        if (tx_we) check("rnd_mem_wdata", mem_wdata_a[0], tx_wdata);
      end
      if (tx_rv == k) begin
        if (tx_own == OWN_IF && if_exp_q.size() > 0) last_if = if_exp_q.pop_front();
        if (tx_own == OWN_D && d_exp_q.size() > 0) last_d = d_exp_q.pop_front();
      end
      check("rnd_if_rdata", if_rdata_a[0], last_if);
      check("rnd_d_rdata", d_rdata_a[0], last_d);

      // requesters
      if (tx_gnt == k && tx_own == OWN_IF) begin
        if_req = 1'b0; if_cool = 1;
      end else if (if_req) begin
        if ($urandom_range(31) == 0) if_req = 1'b0;
      end else if (if_cool) begin
        if_cool = 0;
      end else if ($urandom_range(3) == 0) begin
        if_req = 1'b1; if_addr = 32'h1000 + ($urandom_range(15) << 3);
      end
      if (tx_gnt == k && tx_own == OWN_D) begin
        d_req = 1'b0; d_cool = 1;
      end else if (d_req) begin
        if ($urandom_range(31) == 0) d_req = 1'b0;
      end else if (d_cool) begin
        d_cool = 0;
      end else if ($urandom_range(2) == 0) begin
        d_req = 1'b1; d_we = $urandom_range(1);
        d_addr = 32'h1000 + ($urandom_range(15) << 3);
        d_wdata = {$urandom, $urandom};
      end

      // model: the arbiter looks at requests only on cycles it is idle
      if (k == free_at) begin
        if (if_req || d_req) begin
          dw = d_req && !(if_req && starve == STARVE_MAX);
          if (!dw) starve = 0;
          else if (if_req && starve < STARVE_MAX) starve++;
          tx_gnt   = k + 1;
          tx_own   = dw ? OWN_D : OWN_IF;
          tx_we    = dw && d_we;
          tx_addr  = dw ? d_addr : if_addr;
          tx_wdata = d_wdata;
          if (tx_we) begin
            ref_mem[tx_addr] = tx_wdata;
            tx_rv   = -1;
            free_at = k + 2;
          end else begin
            v = ref_rd(tx_addr);
            if (dw) d_exp_q.push_back(v);
            else if_exp_q.push_back(v);
            tx_rv   = k + LAT0 + 2;
            free_at = k + LAT0 + 3;
          end
        end else begin
          free_at = k + 1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
